idct_1d: RTL

- 8-point one-dimensional inverse DCT stage; the inverse-direction counterpart of the forward 1-D DCT stage.
- Accepts one frequency coefficient per enabled cycle, in natural order k=0..7.
- Emits the 8 reconstructed samples, n=0..7, serially with a valid strobe.
- Two instances plus transpose memories form the 2-D IDCT decode path; the output strobe drives the next stage's enb directly.

---
 rtl/idct_1d.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/idct_1d.sv
// idct_1d: 8-point 1-D inverse DCT, serial coefficients in, serial samples out.
// Optional output clamping when IDCT_SAT_EN is defined (default: wrap).
module idct_1d #(
    parameter int BWi = 12,
    parameter int BWo = 10,
    parameter int FB  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enb,
    input  logic signed [BWi-1:0] idct_data_in,
    output logic signed [BWo-1:0] idct_data_out,
    output logic                  out_enb
);

    localparam int CW   = 11;
    localparam int PW   = BWi + CW;
    localparam int ACCW = BWi + FB + 3;
    localparam int SW   = ACCW - FB;
    localparam logic [ACCW-1:0] HALF = ACCW'(1 << (FB - 1));

    logic        [2:0]      k_q, k_d;
    logic signed [ACCW-1:0] acc_q [8];
    logic signed [ACCW-1:0] acc_d [8];
    logic        [BWo-1:0]  bank_q [8];
    logic        [BWo-1:0]  bank_d [8];
    logic        [2:0]      oidx_q, oidx_d;
    logic                   oen_q, oen_d;
    logic        [BWo-1:0]  dout_q, dout_d;

    logic signed [PW-1:0]   prod [8];
    logic        [7:0][ACCW-1:0] rnd;
    logic        [BWo-1:0]  y [8];
    logic                   done;
    logic                   unused_rnd;

    // Cosine table: angle index m = (2n+1)k mod 32 folded into one octant.
    function automatic logic signed [CW-1:0] coef(
        input logic [2:0] n,
        input logic [2:0] k
    );
        logic [4:0] m;
        logic [2:0] j;
        logic       neg;
        logic [9:0] mag;
        m   = {1'b0, n, 1'b1} * {2'b00, k};
        j   = m[3] ? (3'd0 - m[2:0]) : m[2:0];
        neg = m[4] ^ m[3];
        unique case (j)
            3'd0: mag = 10'd362;
            3'd1: mag = 10'd502;
            3'd2: mag = 10'd473;
            3'd3: mag = 10'd426;
            3'd4: mag = 10'd362;
            3'd5: mag = 10'd284;
            3'd6: mag = 10'd196;
            3'd7: mag = 10'd100;
        endcase
        coef = neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    endfunction

    // Datapath: products, running sums, rounding and output reduction.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            prod[i] = idct_data_in * coef(3'(i), k_q);
            rnd[i]  = acc_q[i]
                    + $signed({{(ACCW-PW){prod[i][PW-1]}}, prod[i]})
                    + HALF;
`ifdef IDCT_SAT_EN
            if ($signed(rnd[i][ACCW-1:FB]) >
                $signed(SW'((1 << (BWo - 1)) - 1)))
                y[i] = {1'b0, {(BWo-1){1'b1}}};
            else if ($signed(rnd[i][ACCW-1:FB]) <
                     $signed(SW'(-(1 << (BWo - 1)))))
                y[i] = {1'b1, {(BWo-1){1'b0}}};
            else
                y[i] = rnd[i][FB +: BWo];
`else
            y[i] = rnd[i][FB +: BWo];
`endif
        end
    end

    assign unused_rnd = ^rnd;
    assign done       = enb && (k_q == 3'd7);

    // Control: input index, accumulators, output bank and serial emitter.
    always_comb begin
        k_d    = k_q;
        acc_d  = acc_q;
        bank_d = bank_q;
        oidx_d = oidx_q;
        oen_d  = oen_q;
        dout_d = dout_q;
        if (enb) begin
            k_d = k_q + 3'd1;
            for (int i = 0; i < 8; i++) begin
                if (done) begin
                    acc_d[i]  = '0;
                    bank_d[i] = y[i];
                end else begin
                    acc_d[i] = $signed(rnd[i] - HALF);
                end
            end
        end
        if (done) begin
            dout_d = y[0];
            oen_d  = 1'b1;
            oidx_d = 3'd1;
        end else if (oen_q) begin
            if (oidx_q == 3'd0) begin
                oen_d = 1'b0;
            end else begin
                dout_d = bank_q[oidx_q];
                oidx_d = oidx_q + 3'd1;
            end
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_q    <= '0;
            oidx_q <= '0;
            oen_q  <= 1'b0;
            dout_q <= '0;
            for (int i = 0; i < 8; i++) begin
                acc_q[i]  <= '0;
                bank_q[i] <= '0;
            end
        end else begin
            k_q    <= k_d;
            oidx_q <= oidx_d;
            oen_q  <= oen_d;
            dout_q <= dout_d;
            for (int i = 0; i < 8; i++) begin
                acc_q[i]  <= acc_d[i];
                bank_q[i] <= bank_d[i];
            end
        end
    end

    assign idct_data_out = $signed(dout_q);
    assign out_enb       = oen_q;

endmodule
